// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and baud default for the serial program loader
package loader_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_LEN = 3'd1;
  localparam logic [2:0] ST_LOAD     = 3'd2;
  localparam logic [2:0] ST_WAIT_SUM = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;
  localparam logic [2:0] ST_ERR      = 3'd5;

  localparam int CLKS_PER_BIT_DEFAULT = 434;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_WAIT_LEN = ST_WAIT_LEN,
    S_LOAD     = ST_LOAD,
    S_WAIT_SUM = ST_WAIT_SUM,
    S_DONE     = ST_DONE,
    S_ERR      = ST_ERR
  } loader_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with false-start rejection
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESETn,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          sync1_q, sync2_q, prev_q;
  logic          valid_q, valid_d, ferr_q, ferr_d;

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sync1_q <= RXD;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check mid start bit; a line back high means a glitch, not a frame
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART bootloader writing a checksummed image into 256x8 memory
module program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESETn,
  input  logic       RXD,
  input  logic       START,
  output logic       MemWrite,
  output logic [7:0] ADDR,
  output logic [7:0] Data_in,
  output logic       CPU_HOLD,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic [7:0] BYTE_COUNT
);

  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLOCK_50 (CLOCK_50),
    .RESETn   (RESETn),
    .RXD      (RXD),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  loader_state_e state_q, state_d;
  logic [8:0]    len_q, len_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          we_q, we_d;

  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // Any byte arriving here is dropped, including one coincident with START
        if (START) begin
          state_d = S_WAIT_LEN;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      S_WAIT_LEN: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          len_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          we_d   = 1'b1;
          addr_d = cnt_q[7:0];
          data_d = rx_data;
          sum_d  = sum_q + rx_data;
          cnt_d  = cnt_q + 9'd1;
          if (cnt_q + 9'd1 == len_q) state_d = S_WAIT_SUM;
        end
      end
      S_WAIT_SUM: begin
        if (rx_ferr) begin
          state_d = S_ERR;
        end else if (rx_valid) begin
          state_d = (rx_data == sum_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MemWrite   = we_q;
  assign ADDR       = addr_q;
  assign Data_in    = data_q;
  assign BUSY       = (state_q == S_WAIT_LEN) || (state_q == S_LOAD) || (state_q == S_WAIT_SUM);
  assign DONE       = (state_q == S_DONE);
  assign ERROR      = (state_q == S_ERR);
  // A failed load keeps the processor held so it never runs a corrupt image
  assign CPU_HOLD   = BUSY || ERROR;
  assign BYTE_COUNT = cnt_q[8] ? 8'hFF : cnt_q[7:0];

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed vector bench for program_loader
module tb_program_loader;

  localparam int CPB = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESETn   = 1'b0;
  logic       RXD      = 1'b1;
  logic       START    = 1'b0;
  logic       MemWrite, CPU_HOLD, BUSY, DONE, ERROR;
  logic [7:0] ADDR, Data_in, BYTE_COUNT;

  int total = 0;
  int bad   = 0;
  logic [15:0] wq[$];

  program_loader #(.CLKS_PER_BIT(CPB)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESETn     (RESETn),
    .RXD        (RXD),
    .START      (START),
    .MemWrite   (MemWrite),
    .ADDR       (ADDR),
    .Data_in    (Data_in),
    .CPU_HOLD   (CPU_HOLD),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERROR      (ERROR),
    .BYTE_COUNT (BYTE_COUNT)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (MemWrite === 1'b1) wq.push_back({ADDR, Data_in});
  end

  typedef struct {
    logic [7:0]       len;
    logic [2:0][7:0]  d;
    logic [7:0]       csum;
    logic             stop_ok;
    int               nwr;
    logic             exp_done;
    logic             exp_err;
    logic             exp_hold;
    logic [7:0]       exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge CLOCK_50);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLOCK_50);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (CPB) @(negedge CLOCK_50);
    end
    RXD = stop_bit;
    repeat (CPB) @(negedge CLOCK_50);
    RXD = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50);
    START = 1'b1;
    @(negedge CLOCK_50);
    START = 1'b0;
  endtask

  initial begin
    int nerr;
    vecs[0] = '{len: 8'h03, d: {8'h33, 8'h22, 8'h11}, csum: 8'h66, stop_ok: 1'b1, nwr: 3,
                exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0, exp_cnt: 8'd3};
    vecs[1] = '{len: 8'h02, d: {8'h00, 8'h05, 8'hA0}, csum: 8'h00, stop_ok: 1'b1, nwr: 2,
                exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1, exp_cnt: 8'd2};
    vecs[2] = '{len: 8'h01, d: {8'h00, 8'h00, 8'hFF}, csum: 8'hFF, stop_ok: 1'b1, nwr: 1,
                exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0, exp_cnt: 8'd1};
    vecs[3] = '{len: 8'h02, d: {8'h00, 8'h80, 8'h80}, csum: 8'h00, stop_ok: 1'b1, nwr: 2,
                exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0, exp_cnt: 8'd2};
    vecs[4] = '{len: 8'h01, d: {8'h00, 8'h00, 8'h00}, csum: 8'h00, stop_ok: 1'b0, nwr: 0,
                exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1, exp_cnt: 8'd0};

    repeat (3) @(negedge CLOCK_50);
    RESETn = 1'b1;
    @(negedge CLOCK_50);
    chk("reset_outputs", {MemWrite, CPU_HOLD, BUSY, DONE, ERROR, ADDR, Data_in, BYTE_COUNT}, 32'd0);

    // Byte in IDLE is discarded
    wq.delete();
    send_byte(8'h42, 1'b1);
    repeat (5) @(negedge CLOCK_50);
    chk("idle_byte_writes", wq.size(), 0);
    chk("idle_byte_flags", {CPU_HOLD, BUSY, DONE, ERROR}, 4'b0000);

    foreach (vecs[v]) begin
      wq.delete();
      pulse_start();
      chk($sformatf("v%0d_after_start", v), {CPU_HOLD, BUSY, DONE, ERROR, BYTE_COUNT}, {4'b1100, 8'd0});
      send_byte(vecs[v].len, vecs[v].stop_ok);
      if (vecs[v].stop_ok) begin
        for (int k = 0; k < vecs[v].nwr; k++) send_byte(vecs[v].d[k], 1'b1);
        send_byte(vecs[v].csum, 1'b1);
      end
      repeat (4) @(negedge CLOCK_50);
      chk($sformatf("v%0d_flags", v), {BUSY, DONE, ERROR, CPU_HOLD},
          {1'b0, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_hold});
      chk($sformatf("v%0d_count", v), BYTE_COUNT, vecs[v].exp_cnt);
      chk($sformatf("v%0d_nwrites", v), wq.size(), vecs[v].nwr);
      for (int k = 0; k < vecs[v].nwr && k < wq.size(); k++)
        chk($sformatf("v%0d_write%0d", v, k), wq[k], {k[7:0], vecs[v].d[k]});
    end

    // Glitch in WAIT_LEN and START while busy must both be ignored
    wq.delete();
    pulse_start();
    repeat (5) @(negedge CLOCK_50);
    RXD = 1'b0;
    @(negedge CLOCK_50);
    RXD = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    send_byte(8'h02, 1'b1);
    send_byte(8'h5A, 1'b1);
    pulse_start();
    send_byte(8'h21, 1'b1);
    send_byte(8'h7B, 1'b1);
    repeat (4) @(negedge CLOCK_50);
    chk("glitch_flags", {BUSY, DONE, ERROR, CPU_HOLD}, 4'b0100);
    chk("glitch_count", BYTE_COUNT, 8'd2);
    chk("glitch_nwrites", wq.size(), 2);
    if (wq.size() == 2) chk("glitch_writes", {wq[0], wq[1]}, {16'h005A, 16'h0121});

    // Full 256-byte image
    wq.delete();
    pulse_start();
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) send_byte(i[7:0], 1'b1);
    chk("full_wait_sum_busy", {BUSY, DONE}, 2'b10);
    send_byte(8'h80, 1'b1);
    repeat (20) @(negedge CLOCK_50);
    chk("full_nwrites", wq.size(), 256);
    nerr = 0;
    for (int i = 0; i < 256 && i < wq.size(); i++)
      if (wq[i] !== {i[7:0], i[7:0]}) nerr++;
    chk("full_write_seq_errors", nerr, 0);
    if (wq.size() > 0) chk("full_last_write", wq[wq.size()-1], 16'hFFFF);
    chk("full_flags", {BUSY, DONE, ERROR, CPU_HOLD}, 4'b0100);
    chk("full_count", BYTE_COUNT, 8'hFF);

    // Reset in the middle of a load
    wq.delete();
    pulse_start();
    send_byte(8'h05, 1'b1);
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    chk("midload_busy", {BUSY, CPU_HOLD, BYTE_COUNT}, {2'b11, 8'd2});
    RESETn = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk("midload_reset_outputs", {MemWrite, CPU_HOLD, BUSY, DONE, ERROR, ADDR, Data_in, BYTE_COUNT}, 32'd0);
    RESETn = 1'b1;
    send_byte(8'hC3, 1'b1);
    repeat (4) @(negedge CLOCK_50);
    chk("post_reset_idle", {MemWrite, CPU_HOLD, BUSY, DONE, ERROR, BYTE_COUNT}, 13'd0);
    chk("post_reset_nwrites", wq.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
